uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
UART transmitter that serialises one DATA_WIDTH-bit word into an 8N1-style frame on a single line. A frame is one start bit (0), the data bits LSB first, and one stop bit (1), each lasting CLKS_PER_BIT system clocks. It sits in the simple-uart core beside the receiver, driven by a 125 MHz system clock (8 ns period).

Parameters:
CLKS_PER_BIT, 1085, system clocks per serial bit (125 MHz / 115200 baud); must be >= 2.
DATA_WIDTH, 8, number of data bits per frame.

Ports:
sysclk  input  1  system clock; all logic on its rising edge.
i_rst  input  1  synchronous, active-high reset.
i_tx  input  1  transmit request; level-sensitive and sampled in IDLE.
i_tx_byte  input  DATA_WIDTH  word to send; captured when a request is accepted.
o_tx_serial  output  1  serial line; registered output; idles at 1 (stop-bit level).
o_tx_d  output  1  done flag; high from the start of the stop bit until the next request is accepted.

Behaviour:
- Reset (i_rst=1 at a sysclk edge) takes effect on that edge, regardless of state:
  - state goes to IDLE, o_tx_serial=1, o_tx_d=0;
  - bit counter, clock counter and shift register are cleared.
  - Reset mid-frame aborts the frame; the line returns to 1 on that edge.
- FSM states are IDLE, START, DATA and STOP.
- IDLE:
  - o_tx_serial=1.
  - If i_tx=1 at an edge: latch i_tx_byte, clear o_tx_d, clear counters, go to START.
  - o_tx_serial drives 0 from that same edge, so the start bit appears one cycle after i_tx is sampled high.
  - If i_tx=0: remain in IDLE; o_tx_d holds its value.
- START:
  - o_tx_serial=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - o_tx_serial = latched_byte[bit_index] for CLKS_PER_BIT cycles per bit.
  - Bit order is LSB first (index 0 .. DATA_WIDTH-1).
  - After the last bit, go to STOP.
- STOP:
  - o_tx_serial=1 for CLKS_PER_BIT cycles.
  - o_tx_d goes to 1 on the same edge that enters STOP, then the FSM returns to IDLE.
- Frame length is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles, from the first start-bit cycle to the end of the stop bit.
- i_tx_byte changes after acceptance do not affect the frame in progress.
- i_tx is ignored outside IDLE.
- If i_tx is still 1 when returning to IDLE, the next frame starts immediately (back-to-back). o_tx_d clears on that acceptance edge, so in this case o_tx_d is high for CLKS_PER_BIT+1 cycles.
- The clock counter runs 0..CLKS_PER_BIT-1 and is sized $clog2(CLKS_PER_BIT). The bit index is sized $clog2(DATA_WIDTH).
- All outputs are glitch-free registered outputs.

Test Plan:
- Reset then idle: assert i_rst for 2 cycles, then hold i_tx=0 and i_tx_byte=8'b11001011 for 10 cycles -> o_tx_d=0 and o_tx_serial=1 throughout.
- Start bit: raise i_tx=1 with i_tx_byte=8'b11001011 -> o_tx_serial=0 within 2 cycles and held for CLKS_PER_BIT cycles.
- Data bits: sample mid-bit for each of the 8 bits -> observed sequence 1,1,0,1,0,0,1,1 (LSB first); each bit lasts exactly CLKS_PER_BIT cycles.
- Stop and done: at 3+9*CLKS_PER_BIT cycles after i_tx rises -> o_tx_serial=1 and o_tx_d=1. Total frame length is 10*CLKS_PER_BIT cycles.
- Back-to-back and data latching: hold i_tx=1 and change i_tx_byte to 8'h5A mid-frame -> first frame still sends 8'hCB; second frame sends 8'h5A starting right after the stop bit; o_tx_d drops on the second acceptance.
- Reset mid-frame: assert i_rst during DATA bit 3 -> next edge gives o_tx_serial=1 and o_tx_d=0 with the FSM in IDLE. A new request after reset sends a complete, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, stop bit.
// Each bit lasts CLKS_PER_BIT system clocks; the line idles high.
module uart_tx #(
   parameter int CLKS_PER_BIT = 1085,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  sysclk,
   input  logic                  i_rst,
   input  logic                  i_tx,
   input  logic [DATA_WIDTH-1:0] i_tx_byte,
   output logic                  o_tx_serial,
   output logic                  o_tx_d
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         clk_q, clk_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  serial_q, serial_d;
   logic                  done_q, done_d;

   logic last_clk;

   assign last_clk    = (clk_q == LAST_CLK);
   assign o_tx_serial = serial_q;
   assign o_tx_d      = done_q;

   // State, counters, shift register and registered outputs.
   always_ff @(posedge sysclk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         clk_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         serial_q <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         clk_q    <= clk_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         serial_q <= serial_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic; the serial value is computed one cycle ahead
   // so the line changes on the same edge as the state.
   always_comb begin
      state_d  = state_q;
      clk_d    = clk_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      serial_d = serial_q;
      done_d   = done_q;

      unique case (state_q)
         IDLE: begin
            serial_d = 1'b1;
            clk_d    = '0;
            bit_d    = '0;
            if (i_tx) begin
               shift_d  = i_tx_byte;
               done_d   = 1'b0;
               serial_d = 1'b0;
               state_d  = START;
            end
         end

         START: begin
            if (last_clk) begin
               clk_d    = '0;
               bit_d    = '0;
               serial_d = shift_q[0];
               state_d  = DATA;
            end else begin
               clk_d = clk_q + 1'b1;
            end
         end

         DATA: begin
            if (last_clk) begin
               clk_d = '0;
               if (bit_q == LAST_BIT) begin
                  serial_d = 1'b1;
                  done_d   = 1'b1;
                  state_d  = STOP;
               end else begin
                  bit_d    = bit_q + 1'b1;
                  shift_d  = shift_q >> 1;
                  serial_d = shift_d[0];
               end
            end else begin
               clk_d = clk_q + 1'b1;
            end
         end

         STOP: begin
            serial_d = 1'b1;
            if (last_clk) begin
               clk_d   = '0;
               state_d = IDLE;
            end else begin
               clk_d = clk_q + 1'b1;
            end
         end

         default: begin
            serial_d = 1'b1;
            clk_d    = '0;
            bit_d    = '0;
            state_d  = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a short bit period.
// Expected line values come from the frame layout of each test word.
module tb_uart_tx;

   localparam int CPB = 4;
   localparam int DW  = 8;

   logic          sysclk = 1'b0;
   logic          i_rst;
   logic          i_tx;
   logic [DW-1:0] i_tx_byte;
   logic          o_tx_serial;
   logic          o_tx_d;

   int total = 0;
   int bad   = 0;

   always #4 sysclk = ~sysclk;

   uart_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_WIDTH  (DW)
   ) dut (
      .sysclk     (sysclk),
      .i_rst      (i_rst),
      .i_tx       (i_tx),
      .i_tx_byte  (i_tx_byte),
      .o_tx_serial(o_tx_serial),
      .o_tx_d     (o_tx_d)
   );

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Called just after the accepting edge; checks ncyc cycles of frame.
   task automatic frame(input string tag, input logic [DW-1:0] data,
                        input int ncyc, input int chg_at,
                        input logic [DW-1:0] nb);
      for (int k = 0; k < ncyc; k++) begin
         int   b;
         logic es;
         logic ed;
         b = k / CPB;
         if (b == 0)
            es = 1'b0;
         else if (b <= DW)
            es = data[b-1];
         else
            es = 1'b1;
         ed = (b == DW + 1);
         chk($sformatf("%s_ser_k%0d", tag, k), o_tx_serial, es);
         chk($sformatf("%s_done_k%0d", tag, k), o_tx_d, ed);
         if (k == chg_at) i_tx_byte = nb;
         tick();
      end
   endtask

   initial begin
      i_rst     = 1'b1;
      i_tx      = 1'b0;
      i_tx_byte = 8'b11001011;
      tick();
      tick();
      chk("rst_ser", o_tx_serial, 1'b1);
      chk("rst_done", o_tx_d, 1'b0);

      i_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("idle_ser_%0d", i), o_tx_serial, 1'b1);
         chk($sformatf("idle_done_%0d", i), o_tx_d, 1'b0);
      end

      i_tx = 1'b1;
      tick();
      frame("f1", 8'hCB, (DW + 2) * CPB, 5 * CPB, 8'h5A);

      chk("gap_ser", o_tx_serial, 1'b1);
      chk("gap_done", o_tx_d, 1'b1);
      tick();
      i_tx = 1'b0;
      frame("f2", 8'h5A, (DW + 2) * CPB, -1, 8'h00);

      chk("end2_ser", o_tx_serial, 1'b1);
      chk("end2_done", o_tx_d, 1'b1);
      tick();
      tick();
      chk("hold_ser", o_tx_serial, 1'b1);
      chk("hold_done", o_tx_d, 1'b1);

      i_tx      = 1'b1;
      i_tx_byte = 8'hA5;
      tick();
      i_tx = 1'b0;
      frame("f3", 8'hA5, 4 * CPB + 1, -1, 8'h00);
      i_rst = 1'b1;
      tick();
      chk("mid_rst_ser", o_tx_serial, 1'b1);
      chk("mid_rst_done", o_tx_d, 1'b0);
      i_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst_ser_%0d", i), o_tx_serial, 1'b1);
         chk($sformatf("post_rst_done_%0d", i), o_tx_d, 1'b0);
      end

      i_tx      = 1'b1;
      i_tx_byte = 8'h3C;
      tick();
      i_tx = 1'b0;
      frame("f4", 8'h3C, (DW + 2) * CPB, -1, 8'h00);
      chk("end4_ser", o_tx_serial, 1'b1);
      chk("end4_done", o_tx_d, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
